// File: rtl/tqvp_diff_pkg.sv
// Shared constants and types for the TinyQV differentiator peripheral:
// register map, CTRL/STATUS bit positions, FIFO depth and saturation limits.
package tqvp_diff_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_IN_LO  = 4'h2;
    localparam logic [3:0] ADDR_IN_HI  = 4'h3;
    localparam logic [3:0] ADDR_OUT_LO = 4'h4;
    localparam logic [3:0] ADDR_OUT_HI = 4'h5;
    localparam logic [3:0] ADDR_SCALE  = 4'h6;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_ORDER = 1;
    localparam int CTRL_SAT   = 2;
    localparam int CTRL_EXT   = 3;
    localparam int CTRL_M_LO  = 4;
    localparam int CTRL_CLEAR = 7;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_SAT       = 3;
    localparam int ST_COUNT_LO  = 4;

    localparam int FIFO_DEPTH = 4;
    localparam int RES_W      = 16;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // Field order mirrors CTRL[5:0], so a write can be cast straight in.
    typedef struct packed {
        logic [1:0] m_minus1;
        logic       ext_mode;
        logic       sat_en;
        logic       order;
        logic       enable;
    } ctrl_t;

endpackage

// File: rtl/diff_comb_stage.sv
// One comb stage: a MAX_DELAY-deep history line and y = x - x[n-M],
// evaluated one bit wider than the input so the difference never wraps.
module diff_comb_stage #(
    parameter int W_IN      = 16,
    parameter int MAX_DELAY = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         shift_i,
    input  logic [$clog2(MAX_DELAY)-1:0] delay_sel_i,
    input  logic signed [W_IN-1:0]       x_i,
    output logic signed [W_IN:0]         diff_o
);

    logic signed [W_IN-1:0] hist_q [MAX_DELAY];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which is what makes the shift register shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DELAY; i++) hist_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < MAX_DELAY; i++) hist_q[i] <= '0;
        end else if (shift_i) begin
            hist_q[0] <= x_i;
            for (int i = 1; i < MAX_DELAY; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    assign diff_o = {x_i[W_IN-1], x_i} - {hist_q[delay_sel_i][W_IN-1], hist_q[delay_sel_i]};

endmodule

// File: rtl/tqvp_differentiator.sv
// TinyQV differentiator peripheral: one or two comb stages, arithmetic
// scaling, wrap/saturate, and a small result FIFO drained over the register bus.
module tqvp_differentiator
    import tqvp_diff_pkg::*;
#(
    parameter int FIFO_DEPTH = tqvp_diff_pkg::FIFO_DEPTH,
    parameter int IN_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [IN_W+1:0] R_MAX = (IN_W+2)'(SAT_MAX);
    localparam logic signed [IN_W+1:0] R_MIN = (IN_W+2)'(SAT_MIN);

    ctrl_t             ctrl_q;
    logic [7:0]        in_lo_q, in_hi_q;
    logic [2:0]        scale_q;
    logic [7:0]        sync1_q, sync2_q;
    logic              strobe_prev_q;
    logic              v0_q, v1_q;
    logic signed [IN_W-1:0] x_q;
    logic signed [IN_W:0]   d1_q;
    logic [RES_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, sat_q;
    logic [7:0]        uo_q;

    logic wr_ctrl, wr_status, wr_in_lo, wr_in_hi, wr_pop, wr_scale, clear;
    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_status = data_write && (address == ADDR_STATUS);
    assign wr_in_lo  = data_write && (address == ADDR_IN_LO);
    assign wr_in_hi  = data_write && (address == ADDR_IN_HI);
    assign wr_pop    = data_write && (address == ADDR_OUT_HI);
    assign wr_scale  = data_write && (address == ADDR_SCALE);
    assign clear     = wr_ctrl && data_in[CTRL_CLEAR];

    // Acceptance source: bus commit, or a synchronized strobe rising edge.
    logic                   rise, accept, adv1, push_req;
    logic signed [IN_W-1:0] sample;
    assign rise     = sync2_q[7] && !strobe_prev_q;
    assign accept   = ctrl_q.enable && !clear && (ctrl_q.ext_mode ? rise : wr_in_hi);
    assign sample   = ctrl_q.ext_mode ? {(IN_W-7)'(0), sync2_q[6:0]}
                                      : IN_W'({data_in, in_lo_q});
    assign adv1     = v0_q && ctrl_q.enable && !clear;
    assign push_req = v1_q && ctrl_q.enable && !clear;

    logic signed [IN_W:0]   d1;
    logic signed [IN_W+1:0] d2;

    diff_comb_stage #(.W_IN(IN_W), .MAX_DELAY(4)) u_stage1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .shift_i     (adv1),
        .delay_sel_i (ctrl_q.m_minus1),
        .x_i         (x_q),
        .diff_o      (d1)
    );

    // Stage 2 always advances so switching order keeps a valid history.
    diff_comb_stage #(.W_IN(IN_W+1), .MAX_DELAY(4)) u_stage2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .shift_i     (push_req),
        .delay_sel_i (ctrl_q.m_minus1),
        .x_i         (d1_q),
        .diff_o      (d2)
    );

    logic signed [IN_W+1:0] sel, scaled;
    logic [RES_W-1:0]       res;
    logic                   clamp;

    // NOTE: every always_comb output gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        sel    = ctrl_q.order ? d2 : {d1_q[IN_W], d1_q};
        scaled = sel >>> scale_q;
        res    = scaled[RES_W-1:0];
        clamp  = 1'b0;
        if (ctrl_q.sat_en) begin
            if (scaled > R_MAX) begin
                res   = SAT_MAX;
                clamp = 1'b1;
            end else if (scaled < R_MIN) begin
                res   = SAT_MIN;
                clamp = 1'b1;
            end
        end
    end

    logic full, empty, do_pop, do_push, ovf_set;
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = wr_pop && !empty && !clear;
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && full && !do_pop;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q        <= '0;
            in_lo_q       <= '0;
            in_hi_q       <= '0;
            scale_q       <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            strobe_prev_q <= 1'b0;
            v0_q          <= 1'b0;
            v1_q          <= 1'b0;
            x_q           <= '0;
            d1_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            sat_q         <= 1'b0;
            uo_q          <= '0;
        end else begin
            sync1_q       <= ui_in;
            sync2_q       <= sync1_q;
            strobe_prev_q <= sync2_q[7];
            if (wr_ctrl)  ctrl_q  <= ctrl_t'(data_in[5:0]);
            if (wr_in_lo) in_lo_q <= data_in;
            if (wr_in_hi) in_hi_q <= data_in;
            if (wr_scale) scale_q <= data_in[2:0];

            v0_q <= accept;
            if (accept) x_q <= sample;
            v1_q <= adv1;
            if (adv1) d1_q <= d1;

            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
                sat_q    <= 1'b0;
                uo_q     <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    uo_q     <= res[7:0];
                end
                if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
                if (ovf_set)                          ovf_q <= 1'b1;
                else if (wr_status && data_in[ST_OVF]) ovf_q <= 1'b0;
                if (push_req && clamp)                sat_q <= 1'b1;
                else if (wr_status && data_in[ST_SAT]) sat_q <= 1'b0;
            end
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only readable after a push
    // writes it, and reads of an empty FIFO are forced to zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= res;
    end

    logic [RES_W-1:0] head;
    logic [7:0]       status;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        status                      = '0;
        status[ST_NOT_EMPTY]        = !empty;
        status[ST_FULL]             = full;
        status[ST_OVF]              = ovf_q;
        status[ST_SAT]              = sat_q;
        status[ST_COUNT_LO +: 3]    = 3'(count_q);
        data_out = '0;
        case (address)
            ADDR_CTRL:   data_out = {2'b00, ctrl_q};
            ADDR_STATUS: data_out = status;
            ADDR_IN_LO:  data_out = in_lo_q;
            ADDR_IN_HI:  data_out = in_hi_q;
            ADDR_OUT_LO: data_out = empty ? 8'h00 : head[7:0];
            ADDR_OUT_HI: data_out = empty ? 8'h00 : head[15:8];
            ADDR_SCALE:  data_out = {5'b00000, scale_q};
            default:     data_out = '0;
        endcase
    end

    assign uo_out = uo_q;

endmodule

// File: tb/tb_tqvp_differentiator.sv
// Directed bench for tqvp_differentiator: expected results go into a
// scoreboard queue, drained values are compared by a separate monitor.
module tb_tqvp_differentiator;
    import tqvp_diff_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in, uo_out, data_in, data_out;
    logic [3:0] address;
    logic       data_write;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    tqvp_differentiator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(name, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic commit(input logic [15:0] val, input bit expect_push, input logic [15:0] exp);
        wr(ADDR_IN_LO, val[7:0]);
        wr(ADDR_IN_HI, val[15:8]);
        if (expect_push) exp_q.push_back(exp);
    endtask

    task automatic pop_one();
        logic [7:0] lo, hi;
        rd(ADDR_OUT_LO, lo);
        rd(ADDR_OUT_HI, hi);
        obs_q.push_back({hi, lo});
        wr(ADDR_OUT_HI, 8'h00);
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    // Monitor: compares each drained FIFO head against the scoreboard.
    initial begin
        logic [15:0] got;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got 0x%0h with nothing expected", got);
                end else begin
                    check("fifo_result", {16'h0, got}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [15:0] fo_vals [4] = '{16'd0, 16'd1, 16'd4, 16'd9};
        logic [15:0] fo_exp  [4] = '{16'd0, 16'd1, 16'd2, 16'd2};
        logic [15:0] ov_vals [5] = '{16'd10, 16'd30, 16'd60, 16'd100, 16'd150};
        logic [15:0] ov_exp  [5] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
        logic [7:0]  lo, hi;

        rst_n      = 1'b0;
        ui_in      = 8'h00;
        address    = 4'h0;
        data_in    = 8'h00;
        data_write = 1'b0;
        #12;
        for (int a = 0; a < 16; a++) check_reg("reset_data_out", 4'(a), 8'h00);
        check("reset_uo_out", {24'h0, uo_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First-order difference, M=1.
        wr(ADDR_CTRL, 8'h81);
        check_reg("ctrl_readback", ADDR_CTRL, 8'h01);
        commit(16'h0064, 1'b1, 16'h0064);
        commit(16'h00C8, 1'b1, 16'h0064);
        settle();
        check_reg("first_order_status", ADDR_STATUS, 8'h21);
        check("first_order_uo", {24'h0, uo_out}, 32'h64);
        pop_one();
        pop_one();
        check_reg("first_order_drained", ADDR_STATUS, 8'h00);

        // Second-order difference of squares.
        wr(ADDR_CTRL, 8'h83);
        for (int i = 0; i < 4; i++) begin
            commit(fo_vals[i], 1'b1, fo_exp[i]);
            settle();
            pop_one();
        end

        // Wrap then saturate.
        wr(ADDR_CTRL, 8'h81);
        commit(16'h7FF0, 1'b1, 16'h7FF0);
        commit(16'h8010, 1'b1, 16'h0020);
        settle();
        check_reg("wrap_status", ADDR_STATUS, 8'h21);
        pop_one();
        pop_one();
        wr(ADDR_CTRL, 8'h85);
        commit(16'h7FF0, 1'b1, 16'h7FF0);
        commit(16'h8010, 1'b1, 16'h8000);
        settle();
        check_reg("sat_status", ADDR_STATUS, 8'h29);
        pop_one();
        pop_one();
        wr(ADDR_STATUS, 8'h08);
        check_reg("sat_w1c", ADDR_STATUS, 8'h00);

        // FIFO overflow, then simultaneous pop and push while full.
        wr(ADDR_CTRL, 8'h81);
        for (int i = 0; i < 5; i++) commit(ov_vals[i], i < 4, ov_exp[i]);
        settle();
        check_reg("ovf_status", ADDR_STATUS, 8'h47);
        check_reg("ovf_head", ADDR_OUT_LO, 8'h0A);
        check("ovf_uo_kept", {24'h0, uo_out}, 32'h28);
        wr(ADDR_STATUS, 8'h04);
        check_reg("ovf_w1c", ADDR_STATUS, 8'h43);
        commit(16'd200, 1'b1, 16'd50);
        tick();
        rd(ADDR_OUT_LO, lo);
        rd(ADDR_OUT_HI, hi);
        obs_q.push_back({hi, lo});
        wr(ADDR_OUT_HI, 8'h00);
        check_reg("pop_push_full", ADDR_STATUS, 8'h43);
        check("pop_push_uo", {24'h0, uo_out}, 32'h32);
        for (int i = 0; i < 4; i++) pop_one();
        check_reg("ovf_drained", ADDR_STATUS, 8'h00);

        // M=4 with SCALE=1.
        wr(ADDR_CTRL, 8'hB1);
        wr(ADDR_SCALE, 8'h01);
        check_reg("scale_readback", ADDR_SCALE, 8'h01);
        for (int i = 0; i < 5; i++) begin
            commit(16'(8 * (i + 1)), 1'b1, (i == 4) ? 16'd16 : 16'(4 * (i + 1)));
            settle();
            pop_one();
        end
        wr(ADDR_SCALE, 8'h00);

        // External strobe mode.
        wr(ADDR_CTRL, 8'h89);
        ui_in = 8'h05;
        tick();
        tick();
        tick();
        ui_in = 8'h85;
        for (int e = 0; e < 4; e++) tick();
        check_reg("ext_before_push", ADDR_STATUS, 8'h00);
        check("ext_uo_before", {24'h0, uo_out}, 32'h0);
        tick();
        check_reg("ext_after_push", ADDR_STATUS, 8'h11);
        check("ext_uo_after", {24'h0, uo_out}, 32'h05);
        exp_q.push_back(16'h0005);
        pop_one();
        commit(16'h0010, 1'b0, 16'h0000);
        settle();
        check_reg("ext_ignores_in_hi", ADDR_STATUS, 8'h00);

        // Mid-stream reset while a strobe sample is in flight.
        ui_in = 8'h07;
        tick();
        tick();
        tick();
        ui_in = 8'h87;
        for (int e = 0; e < 4; e++) tick();
        rst_n = 1'b0;
        #1;
        check_reg("reset_mid_status", ADDR_STATUS, 8'h00);
        check_reg("reset_mid_ctrl", ADDR_CTRL, 8'h00);
        check("reset_mid_uo", {24'h0, uo_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        check_reg("after_reset_status", ADDR_STATUS, 8'h00);

        tick();
        tick();
        check("pending_expected", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
